// File: rtl/signed_sub_with_saturation_pipe_if.sv
// rtl/signed_sub_with_saturation_pipe_if.sv - upstream/downstream handshake bundle for the saturating subtractor
interface signed_sub_with_saturation_pipe_if #(
  parameter int W = 4
);
  logic         up_valid;
  logic         up_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         down_valid;
  logic         down_ready;
  logic [W-1:0] diff;
  logic         sat;

  modport master (
    output up_valid, a, b, down_ready,
    input  up_ready, down_valid, diff, sat
  );

  modport slave (
    input  up_valid, a, b, down_ready,
    output up_ready, down_valid, diff, sat
  );
endinterface

// File: rtl/signed_sub_with_saturation_pipe.sv
// rtl/signed_sub_with_saturation_pipe.sv - two-stage streaming subtractor, diff = sat(a - b)
// Optional saturation event counter (sat_cnt port, CNT_W parameter) under SUB_SAT_CNT_EN.
module signed_sub_with_saturation_pipe #(
  parameter int W = 4
`ifdef SUB_SAT_CNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic clk,
  input  logic rst,
  signed_sub_with_saturation_pipe_if.slave bus
`ifdef SUB_SAT_CNT_EN
  , output logic [CNT_W-1:0] sat_cnt
`endif
);

  logic         s1_valid_q, s1_valid_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         s2_valid_q, s2_valid_d;
  logic [W-1:0] diff_q, diff_d;
  logic         sat_q, sat_d;
  logic         s1_adv, s2_adv;
  logic [W:0]   raw;
  logic         ovf;
  logic [W-1:0] sat_val;

  always_comb begin
    s2_adv = ~s2_valid_q | bus.down_ready;
    s1_adv = ~s1_valid_q | s2_adv;

    // raw[W] is the true sign; overflow whenever it disagrees with the W-bit sign
    raw     = {a_q[W-1], a_q} - {b_q[W-1], b_q};
    ovf     = raw[W] ^ raw[W-1];
    sat_val = raw[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};

    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    s2_valid_d = s2_valid_q;
    diff_d     = diff_q;
    sat_d      = sat_q;

    if (s1_adv) begin
      s1_valid_d = bus.up_valid;
      if (bus.up_valid) begin
        a_d = bus.a;
        b_d = bus.b;
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        diff_d = ovf ? sat_val : raw[W-1:0];
        sat_d  = ovf;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      s2_valid_q <= 1'b0;
      diff_q     <= '0;
      sat_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      s2_valid_q <= s2_valid_d;
      diff_q     <= diff_d;
      sat_q      <= sat_d;
    end
  end

  assign bus.up_ready   = s1_adv;
  assign bus.down_valid = s2_valid_q;
  assign bus.diff       = diff_q;
  assign bus.sat        = sat_q;

`ifdef SUB_SAT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts consumed saturating results only, sticking at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (s2_valid_q && bus.down_ready && sat_q && !(&cnt_q)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_cnt = cnt_q;
`endif

endmodule
